// File: rtl/maq_pkg.sv
// Shared types, limits and the binary-to-BCD helper for the maq_relogio time-of-day core.
package maq_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t msd;
        bcd_t lsd;
    } bcd_par_t;

    localparam int SEG_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HORA_MAX = 23;

    function automatic bcd_par_t bin_para_bcd(input logic [6:0] v);
        bcd_par_t r;
        r.msd = 4'(v / 7'd10);
        r.lsd = 4'(v % 7'd10);
        return r;
    endfunction

endpackage

// File: rtl/maq_bcd60.sv
// Two-digit BCD modulo-60 counter with a variable step; carry marks a wrap past 59.
module maq_bcd60
    import maq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic [3:0] passo,
    output bcd_t       lsd,
    output logic [2:0] msd,
    output logic       carry
);

    bcd_par_t   q;
    bcd_par_t   prox_bcd;
    logic [6:0] atual;
    logic [6:0] soma;
    logic [6:0] prox;
    logic       volta;

    always_comb begin
        atual    = 7'(q.msd) * 7'd10 + 7'(q.lsd);
        soma     = atual + 7'(passo);
        volta    = (soma > 7'(SEG_MAX));
        prox     = volta ? (soma - 7'd60) : soma;
        prox_bcd = bin_para_bcd(prox);
        carry    = en && !clr && volta;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= prox_bcd;
        end
    end

    assign lsd = q.lsd;
    assign msd = q.msd[2:0];

endmodule

// File: rtl/maq_relogio.sv
// BCD HH:MM:SS time-of-day core with prescaler, set mode and 12/24 h display.
// Optional alarm output is built when MAQ_R_ALARME_EN is defined.
module maq_relogio
    import maq_pkg::*;
#(
    parameter int DIV_TICK     = 1,
    parameter int PASSO_AJUSTE = 1,
    parameter int INICIO_H     = 0
) (
    input  logic       maq_r_clock,
    input  logic       maq_r_reset,
    input  logic       maq_r_enable1hz,
    input  logic       maq_r_modo12,
    input  logic       maq_r_ajuste,
    input  logic       maq_r_incremento_hora,
    input  logic       maq_r_incremento_min,
    input  logic       maq_r_zera_seg,
`ifdef MAQ_R_ALARME_EN
    input  logic [4:0] maq_r_alarme_h,
    input  logic [5:0] maq_r_alarme_m,
    input  logic       maq_r_alarme_liga,
    output logic       maq_r_alarme,
`endif
    output logic [3:0] maq_r_bcd_s_lsd,
    output logic [2:0] maq_r_bcd_s_msd,
    output logic [3:0] maq_r_bcd_m_lsd,
    output logic [2:0] maq_r_bcd_m_msd,
    output logic [3:0] maq_r_bcd_h_lsd,
    output logic [1:0] maq_r_bcd_h_msd,
    output logic       maq_r_pm,
    output logic       maq_r_virada_dia
);

    localparam int            PW     = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
    localparam logic [PW-1:0] P_ULT  = PW'(DIV_TICK - 1);
    localparam bcd_par_t      H_INI  = bin_para_bcd(7'(INICIO_H));

    logic [PW-1:0] p_q;
    logic          passo_seg;
    logic          carry_s;
    logic          carry_m;
    logic          en_m;
    logic [3:0]    passo_m;
    logic          avanca_h;
    bcd_par_t      h_q;
    bcd_par_t      h_prox;
    logic [6:0]    h_bin;
    logic [6:0]    h_soma;
    logic [6:0]    h_aj;
    logic          h_ultima;
    logic [6:0]    h_disp;
    logic          virada_q;

    // zera_seg wins over a same-cycle tick, so that tick never reaches the seconds counter.
    always_comb begin
        passo_seg = maq_r_enable1hz && !maq_r_ajuste && !maq_r_zera_seg && (p_q == P_ULT);
        en_m      = maq_r_ajuste ? (maq_r_enable1hz && maq_r_incremento_min) : carry_s;
        passo_m   = maq_r_ajuste ? 4'(PASSO_AJUSTE) : 4'd1;
        avanca_h  = !maq_r_ajuste && carry_m;
    end

    always_ff @(posedge maq_r_clock or negedge maq_r_reset) begin
        if (!maq_r_reset) begin
            p_q <= '0;
        end else if (maq_r_zera_seg) begin
            p_q <= '0;
        end else if (maq_r_enable1hz && !maq_r_ajuste) begin
            p_q <= (p_q == P_ULT) ? '0 : p_q + PW'(1);
        end
    end

    maq_bcd60 u_seg (
        .clk   (maq_r_clock),
        .rst_n (maq_r_reset),
        .en    (passo_seg),
        .clr   (maq_r_zera_seg),
        .passo (4'd1),
        .lsd   (maq_r_bcd_s_lsd),
        .msd   (maq_r_bcd_s_msd),
        .carry (carry_s)
    );

    maq_bcd60 u_min (
        .clk   (maq_r_clock),
        .rst_n (maq_r_reset),
        .en    (en_m),
        .clr   (1'b0),
        .passo (passo_m),
        .lsd   (maq_r_bcd_m_lsd),
        .msd   (maq_r_bcd_m_msd),
        .carry (carry_m)
    );

    // Normal counting steps the BCD digits directly; set mode adds in binary and reconverts.
    always_comb begin
        h_bin    = 7'(h_q.msd) * 7'd10 + 7'(h_q.lsd);
        h_soma   = h_bin + 7'(PASSO_AJUSTE);
        h_aj     = (h_soma > 7'(HORA_MAX)) ? (h_soma - 7'd24) : h_soma;
        h_ultima = (h_bin == 7'(HORA_MAX));
        h_prox   = h_q;
        if (avanca_h) begin
            if (h_ultima) begin
                h_prox = '0;
            end else if (h_q.lsd == 4'd9) begin
                h_prox.msd = h_q.msd + 4'd1;
                h_prox.lsd = 4'd0;
            end else begin
                h_prox.lsd = h_q.lsd + 4'd1;
            end
        end else if (maq_r_ajuste && maq_r_enable1hz && maq_r_incremento_hora) begin
            h_prox = bin_para_bcd(h_aj);
        end
    end

    always_ff @(posedge maq_r_clock or negedge maq_r_reset) begin
        if (!maq_r_reset) begin
            h_q      <= H_INI;
            virada_q <= 1'b0;
        end else begin
            h_q      <= h_prox;
            virada_q <= avanca_h && h_ultima;
        end
    end

    assign maq_r_virada_dia = virada_q;

    always_comb begin
        h_disp = h_bin;
        if (maq_r_modo12) begin
            if (h_bin == 7'd0) begin
                h_disp = 7'd12;
            end else if (h_bin > 7'd12) begin
                h_disp = h_bin - 7'd12;
            end
        end
        maq_r_bcd_h_lsd = 4'(h_disp % 7'd10);
        maq_r_bcd_h_msd = 2'(h_disp / 7'd10);
        maq_r_pm        = maq_r_modo12 && (h_bin >= 7'd12);
    end

`ifdef MAQ_R_ALARME_EN
    logic virou_min_q;

    // carry_s only occurs on a normal-mode step into second 00, so set mode cannot fire the alarm.
    always_ff @(posedge maq_r_clock or negedge maq_r_reset) begin
        if (!maq_r_reset) begin
            virou_min_q <= 1'b0;
        end else begin
            virou_min_q <= carry_s;
        end
    end

    always_comb begin
        maq_r_alarme = virou_min_q && maq_r_alarme_liga
                    && (h_bin == 7'(maq_r_alarme_h))
                    && ((7'(maq_r_bcd_m_msd) * 7'd10 + 7'(maq_r_bcd_m_lsd)) == 7'(maq_r_alarme_m));
    end
`endif

endmodule

// File: tb/tb_maq_relogio.sv
// Bench for maq_relogio: two parameterisations driven together, checked against a seconds-of-day model.
module tb_maq_relogio;

`ifdef MAQ_R_ALARME_EN
    localparam bit ALARME = 1'b1;
`else
    localparam bit ALARME = 1'b0;
`endif

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic en     = 1'b0;
    logic modo12 = 1'b0;
    logic aj     = 1'b0;
    logic ih     = 1'b0;
    logic im     = 1'b0;
    logic zs     = 1'b0;
    logic [4:0] al_h    = 5'd6;
    logic [5:0] al_m    = 6'd30;
    logic       al_liga = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] a_s_lsd, a_m_lsd, a_h_lsd, b_s_lsd, b_m_lsd, b_h_lsd;
    logic [2:0] a_s_msd, a_m_msd, b_s_msd, b_m_msd;
    logic [1:0] a_h_msd, b_h_msd;
    logic       a_pm, a_vir, a_al, b_pm, b_vir, b_al;
    logic [22:0] obs [2];

    always #5 clk = ~clk;

    maq_relogio #(.DIV_TICK(1), .PASSO_AJUSTE(1), .INICIO_H(7)) u_a (
        .maq_r_clock           (clk),
        .maq_r_reset           (rst_n),
        .maq_r_enable1hz       (en),
        .maq_r_modo12          (modo12),
        .maq_r_ajuste          (aj),
        .maq_r_incremento_hora (ih),
        .maq_r_incremento_min  (im),
        .maq_r_zera_seg        (zs),
`ifdef MAQ_R_ALARME_EN
        .maq_r_alarme_h        (al_h),
        .maq_r_alarme_m        (al_m),
        .maq_r_alarme_liga     (al_liga),
        .maq_r_alarme          (a_al),
`endif
        .maq_r_bcd_s_lsd       (a_s_lsd),
        .maq_r_bcd_s_msd       (a_s_msd),
        .maq_r_bcd_m_lsd       (a_m_lsd),
        .maq_r_bcd_m_msd       (a_m_msd),
        .maq_r_bcd_h_lsd       (a_h_lsd),
        .maq_r_bcd_h_msd       (a_h_msd),
        .maq_r_pm              (a_pm),
        .maq_r_virada_dia      (a_vir)
    );

    maq_relogio #(.DIV_TICK(4), .PASSO_AJUSTE(3), .INICIO_H(23)) u_b (
        .maq_r_clock           (clk),
        .maq_r_reset           (rst_n),
        .maq_r_enable1hz       (en),
        .maq_r_modo12          (modo12),
        .maq_r_ajuste          (aj),
        .maq_r_incremento_hora (ih),
        .maq_r_incremento_min  (im),
        .maq_r_zera_seg        (zs),
`ifdef MAQ_R_ALARME_EN
        .maq_r_alarme_h        (al_h),
        .maq_r_alarme_m        (al_m),
        .maq_r_alarme_liga     (al_liga),
        .maq_r_alarme          (b_al),
`endif
        .maq_r_bcd_s_lsd       (b_s_lsd),
        .maq_r_bcd_s_msd       (b_s_msd),
        .maq_r_bcd_m_lsd       (b_m_lsd),
        .maq_r_bcd_m_msd       (b_m_msd),
        .maq_r_bcd_h_lsd       (b_h_lsd),
        .maq_r_bcd_h_msd       (b_h_msd),
        .maq_r_pm              (b_pm),
        .maq_r_virada_dia      (b_vir)
    );

`ifndef MAQ_R_ALARME_EN
    assign a_al = 1'b0;
    assign b_al = 1'b0;
`endif

    assign obs[0] = {a_h_msd, a_h_lsd, a_m_msd, a_m_lsd, a_s_msd, a_s_lsd, a_pm, a_vir, a_al};
    assign obs[1] = {b_h_msd, b_h_lsd, b_m_msd, b_m_lsd, b_s_msd, b_s_lsd, b_pm, b_vir, b_al};

    // Reference model: time kept as integers, normal counting done as seconds-of-day + 1.
    int mh [2];
    int mm [2];
    int ms [2];
    int mp [2];
    bit mvir [2];
    bit mal [2];

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int passo_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int ini_of(input int i);
        return (i == 0) ? 7 : 23;
    endfunction

    function automatic logic [22:0] pk(input int hd, input int m, input int s,
                                       input bit pm, input bit vir, input bit al);
        return {2'(hd / 10), 4'(hd % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10), pm, vir, al};
    endfunction

    function automatic logic [22:0] esperado(input int i);
        int hd;
        hd = mh[i];
        if (modo12) hd = (mh[i] % 12 == 0) ? 12 : (mh[i] % 12);
        return pk(hd, mm[i], ms[i], modo12 && (mh[i] >= 12), mvir[i], mal[i]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int t;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mh[i] = ini_of(i); mm[i] = 0; ms[i] = 0; mp[i] = 0;
                mvir[i] = 1'b0; mal[i] = 1'b0;
            end else begin
                mvir[i] = 1'b0;
                mal[i]  = 1'b0;
                if (zs) begin
                    ms[i] = 0;
                    mp[i] = 0;
                end else if (en && !aj) begin
                    if (mp[i] == div_of(i) - 1) begin
                        mp[i] = 0;
                        t = mh[i] * 3600 + mm[i] * 60 + ms[i] + 1;
                        if (t == 86400) begin
                            t = 0;
                            mvir[i] = 1'b1;
                        end
                        mh[i] = t / 3600;
                        mm[i] = (t / 60) % 60;
                        ms[i] = t % 60;
                        if (ALARME && al_liga && ms[i] == 0 && mh[i] == int'(al_h) && mm[i] == int'(al_m))
                            mal[i] = 1'b1;
                    end else begin
                        mp[i] = mp[i] + 1;
                    end
                end
                if (aj && en) begin
                    if (ih) mh[i] = (mh[i] + passo_of(i)) % 24;
                    if (im) mm[i] = (mm[i] + passo_of(i)) % 60;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [22:0] e;
            e = esperado(i);
            n_vec++;
            if (obs[i] !== e) begin
                n_err++;
                $display("FAIL cycle_check dut%0d t=%0t got=%h exp=%h", i, $time, obs[i], e);
            end
        end
    end

    task automatic lit(input string nm, input int i, input logic [22:0] e);
        n_vec++;
        if (obs[i] !== e) begin
            n_err++;
            $display("FAIL %s dut%0d got=%h exp=%h", nm, i, obs[i], e);
        end
    endtask

    task automatic step(input logic e, input logic a, input logic h, input logic m, input logic z);
        en = e; aj = a; ih = h; im = m; zs = z;
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n, input logic e, input logic a, input logic h, input logic m);
        for (int k = 0; k < n; k++) step(e, a, h, m, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        lit("reset_a", 0, pk(7, 0, 0, 0, 0, 0));
        lit("reset_b", 1, pk(23, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        steps(5, 0, 0, 0, 0);
        lit("hold_no_tick", 0, pk(7, 0, 0, 0, 0, 0));

        // reach 23:59:58 on u_a, then roll the day
        steps(16, 1, 1, 1, 0);
        steps(59, 1, 1, 0, 1);
        steps(58, 1, 0, 0, 0);
        lit("pre_2359_58", 0, pk(23, 59, 58, 0, 0, 0));
        step(1, 0, 0, 0, 0);
        lit("pre_2359_59", 0, pk(23, 59, 59, 0, 0, 0));
        step(1, 0, 0, 0, 0);
        lit("rollover", 0, pk(0, 0, 0, 0, 1, 0));
        step(0, 0, 0, 0, 0);
        lit("virada_one_cycle", 0, pk(0, 0, 0, 0, 0, 0));

        // prescaler of 4 on u_b
        step(0, 0, 0, 0, 1);
        steps(3, 1, 0, 0, 0);
        lit("div4_three_ticks", 1, pk(23, 57, 0, 0, 0, 0));
        step(1, 0, 0, 0, 0);
        lit("div4_fourth_tick", 1, pk(23, 57, 1, 0, 0, 0));
        steps(3, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        lit("zera_on_fourth", 1, pk(23, 57, 0, 0, 0, 0));

        // set mode from 22:58:30
        steps(30, 1, 0, 0, 0);
        steps(22, 1, 1, 1, 0);
        steps(58, 1, 1, 0, 1);
        lit("set_start", 0, pk(22, 58, 30, 0, 0, 0));
        steps(3, 1, 1, 1, 1);
        lit("set_both", 0, pk(1, 1, 30, 0, 0, 0));

        // 12 h display sweep
        modo12 = 1'b1;
        steps(23, 1, 1, 1, 0);
        lit("h12_00", 0, pk(12, 1, 30, 0, 0, 0));
        steps(11, 1, 1, 1, 0);
        lit("h12_11", 0, pk(11, 1, 30, 0, 0, 0));
        step(1, 1, 1, 0, 0);
        lit("h12_12", 0, pk(12, 1, 30, 1, 0, 0));
        step(1, 1, 1, 0, 0);
        lit("h12_13", 0, pk(1, 1, 30, 1, 0, 0));
        steps(10, 1, 1, 1, 0);
        lit("h12_23", 0, pk(11, 1, 30, 1, 0, 0));

        // alarm at 06:30
        al_liga = 1'b1;
        steps(7, 1, 1, 1, 0);
        steps(28, 1, 1, 0, 1);
        steps(29, 1, 0, 0, 0);
        lit("alarm_pre", 0, pk(6, 29, 59, 0, 0, 0));
        step(1, 0, 0, 0, 0);
        lit("alarm_hit", 0, pk(6, 30, 0, 0, 0, ALARME));
        step(0, 0, 0, 0, 0);
        lit("alarm_one_cycle", 0, pk(6, 30, 0, 0, 0, 0));
        step(0, 0, 0, 0, 1);
        steps(60, 1, 1, 0, 1);
        lit("alarm_set_mode", 0, pk(6, 30, 0, 0, 0, 0));

        // randomized phase
        modo12 = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (k % 50 == 0) modo12 = 1'($urandom_range(0, 1));
            if (k % 97 == 0) begin
                al_h    = 5'($urandom_range(0, 23));
                al_m    = 6'($urandom_range(0, 59));
                al_liga = 1'($urandom_range(0, 1));
            end
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 31) == 0));
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end

        steps(2, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
